// File: rtl/ariane_pkg.sv
// Shared core types: BHT update bundle and the BHT update-queue FSM state.
// The queue payload drops the valid bit; the output register carries it.
package ariane_pkg;

    localparam int unsigned BHT_UQ_DEPTH = 4;

    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_update_t;

    typedef struct packed {
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_uq_entry_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWITCH
    } bht_uq_state_e;

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V architectural constants shared by the core.
// Only the virtual address width is needed by the BHT update path.
package riscv;

    localparam int unsigned VLEN = 64;

endpackage

// File: rtl/bht_uq_fifo.sv
// Circular FIFO for the BHT update queue; flush empties it in one cycle.
// The caller only pushes when not full or when popping in the same cycle.
module bht_uq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bht_update_queue.sv
// Queues resolved branches into BHT writes and sequences bank switches
// so the old bank receives every queued update before the select flips.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = BHT_UQ_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic                   resolve_valid_i,
    input  logic [riscv::VLEN-1:0] resolve_pc_i,
    input  logic                   resolve_taken_i,
    input  logic                   bht_ready_i,
    output bht_update_t            bht_update_o,
    input  logic                   checkpoint_req_i,
    output logic                   checkpoint_mode_o,
    output logic                   switch_busy_o,
    output logic [CNT_W-1:0]       drop_cnt_o
);

    bht_uq_state_e state_q;
    bht_uq_state_e state_d;

    bht_update_t      out_q;
    bht_update_t      out_d;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;

    bht_uq_entry_t head;
    bht_uq_entry_t res_entry;
    logic          fifo_full;
    logic          fifo_empty;

    logic live;
    logic eligible;
    logic out_free;
    logic pop;
    logic bypass;
    logic push_req;
    logic push;
    logic drop;

    assign res_entry = '{pc: resolve_pc_i, taken: resolve_taken_i};

    assign live     = resolve_valid_i && !debug_mode_i && !flush_i;
    assign eligible = live && (state_q == RUN);
    assign out_free = !out_q.valid || bht_ready_i;
    assign pop      = out_free && !fifo_empty && !flush_i;
    assign bypass   = out_free && fifo_empty && eligible;
    assign push_req = eligible && !bypass;
    assign push     = push_req && (!fifo_full || pop);
    // Outside RUN every live resolve is refused and therefore counted.
    assign drop     = live && ((state_q != RUN) || (push_req && !push));

    bht_uq_fifo #(
        .DEPTH (DEPTH),
        .T     (bht_uq_entry_t)
    ) i_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush_i),
        .push  (push),
        .wdata (res_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        out_d = out_q;
        if (flush_i) begin
            out_d = '0;
        end else if (out_free) begin
            if (pop) begin
                out_d = '{valid: 1'b1, pc: head.pc, taken: head.taken};
            end else if (bypass) begin
                out_d = '{valid: 1'b1, pc: resolve_pc_i,
                          taken: resolve_taken_i};
            end else begin
                out_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q  <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            out_q <= out_d;
            if (state_q == SWITCH) begin
                mode_q <= ~mode_q;
            end
            if (drop && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (checkpoint_req_i != mode_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_i || (fifo_empty && out_free)) begin
                    state_d = SWITCH;
                end
            end
            SWITCH:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        switch_busy_o     = (state_q != RUN);
        checkpoint_mode_o = mode_q;
        bht_update_o      = out_q;
        drop_cnt_o        = cnt_q;
    end

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue: bypass, back-pressure, drops,
// bank switch sequencing, flush and reset.
module tb_bht_update_queue;
    import ariane_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   debug_mode;
    logic                   resolve_valid;
    logic [riscv::VLEN-1:0] resolve_pc;
    logic                   resolve_taken;
    logic                   bht_ready;
    bht_update_t            bht_update;
    logic                   checkpoint_req;
    logic                   checkpoint_mode;
    logic                   switch_busy;
    logic [15:0]            drop_cnt;

    int checks;
    int failures;

    bht_update_queue #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .debug_mode_i      (debug_mode),
        .resolve_valid_i   (resolve_valid),
        .resolve_pc_i      (resolve_pc),
        .resolve_taken_i   (resolve_taken),
        .bht_ready_i       (bht_ready),
        .bht_update_o      (bht_update),
        .checkpoint_req_i  (checkpoint_req),
        .checkpoint_mode_o (checkpoint_mode),
        .switch_busy_o     (switch_busy),
        .drop_cnt_o        (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs,
                         input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] pc, input logic tk);
        resolve_valid = 1'b1;
        resolve_pc    = pc;
        resolve_taken = tk;
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [63:0] pc,
                             input logic tk);
        check({tag, "_valid"}, 80'(bht_update.valid), 80'(1));
        check({tag, "_pc"}, 80'(bht_update.pc), 80'(pc));
        check({tag, "_taken"}, 80'(bht_update.taken), 80'(tk));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        flush          = 1'b0;
        debug_mode     = 1'b0;
        resolve_valid  = 1'b0;
        resolve_pc     = '0;
        resolve_taken  = 1'b0;
        bht_ready      = 1'b1;
        checkpoint_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", 80'(bht_update.valid), 80'(0));
        check("rst_pc", 80'(bht_update.pc), 80'(0));
        check("rst_mode", 80'(checkpoint_mode), 80'(0));
        check("rst_busy", 80'(switch_busy), 80'(0));
        check("rst_drop", 80'(drop_cnt), 80'(0));

        // single resolve, bypass path
        send(64'h8000_0040, 1'b1);
        check_out("single", 64'h8000_0040, 1'b1);
        tick();
        check("single_gone", 80'(bht_update.valid), 80'(0));

        // debug-mode resolve is ignored and not counted
        debug_mode    = 1'b1;
        send(64'h50, 1'b1);
        debug_mode    = 1'b0;
        check("debug_valid", 80'(bht_update.valid), 80'(0));
        check("debug_drop", 80'(drop_cnt), 80'(0));

        // back-pressure: 1 output + 4 queued + 1 dropped
        bht_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(64'h100 + 64'(i * 4), i[0]);
        end
        check("bp_nodrop", 80'(drop_cnt), 80'(0));
        send(64'h114, 1'b1);
        check("bp_drop", 80'(drop_cnt), 80'(1));
        tick();
        check_out("bp_hold", 64'h100, 1'b0);
        bht_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            check_out("bp_drain", 64'h100 + 64'(i * 4), i[0]);
        end
        tick();
        check("bp_empty", 80'(bht_update.valid), 80'(0));

        // full FIFO with a simultaneous pop accepts the resolve
        bht_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(64'h200 + 64'(i * 4), 1'b0);
        end
        bht_ready = 1'b1;
        send(64'h300, 1'b1);
        check("fullpop_drop", 80'(drop_cnt), 80'(1));
        check_out("fullpop_0", 64'h204, 1'b0);
        tick();
        check_out("fullpop_1", 64'h208, 1'b0);
        tick();
        check_out("fullpop_2", 64'h20c, 1'b0);
        tick();
        check_out("fullpop_3", 64'h210, 1'b0);
        tick();
        check_out("fullpop_4", 64'h300, 1'b1);
        tick();
        check("fullpop_empty", 80'(bht_update.valid), 80'(0));

        // bank switch with three pending updates
        bht_ready = 1'b0;
        send(64'h400, 1'b1);
        send(64'h404, 1'b0);
        send(64'h408, 1'b1);
        checkpoint_req = 1'b1;
        tick();
        check("sw_busy", 80'(switch_busy), 80'(1));
        check("sw_mode0", 80'(checkpoint_mode), 80'(0));
        send(64'h500, 1'b1);
        check("sw_drain_drop", 80'(drop_cnt), 80'(2));
        check_out("sw_hold", 64'h400, 1'b1);
        bht_ready = 1'b1;
        tick();
        check_out("sw_u1", 64'h404, 1'b0);
        tick();
        check_out("sw_u2", 64'h408, 1'b1);
        check("sw_mode1", 80'(checkpoint_mode), 80'(0));
        tick();
        check("sw_switch_valid", 80'(bht_update.valid), 80'(0));
        check("sw_switch_busy", 80'(switch_busy), 80'(1));
        check("sw_switch_mode", 80'(checkpoint_mode), 80'(0));
        tick();
        check("sw_done_mode", 80'(checkpoint_mode), 80'(1));
        check("sw_done_busy", 80'(switch_busy), 80'(0));

        // flush during drain goes straight to SWITCH
        bht_ready = 1'b0;
        send(64'h600, 1'b0);
        send(64'h604, 1'b1);
        send(64'h608, 1'b0);
        checkpoint_req = 1'b0;
        tick();
        check("fl_busy", 80'(switch_busy), 80'(1));
        flush         = 1'b1;
        send(64'h700, 1'b1);
        flush         = 1'b0;
        check("fl_valid", 80'(bht_update.valid), 80'(0));
        check("fl_drop", 80'(drop_cnt), 80'(2));
        check("fl_busy2", 80'(switch_busy), 80'(1));
        check("fl_mode", 80'(checkpoint_mode), 80'(1));
        tick();
        check("fl_mode_after", 80'(checkpoint_mode), 80'(0));
        check("fl_busy_after", 80'(switch_busy), 80'(0));
        bht_ready = 1'b1;
        tick();
        check("fl_stays_empty", 80'(bht_update.valid), 80'(0));

        // flush in RUN with a resolve in the same cycle
        bht_ready = 1'b0;
        send(64'h800, 1'b0);
        send(64'h804, 1'b1);
        flush = 1'b1;
        send(64'h808, 1'b1);
        flush = 1'b0;
        check("flr_valid", 80'(bht_update.valid), 80'(0));
        check("flr_drop", 80'(drop_cnt), 80'(2));
        bht_ready = 1'b1;
        send(64'h900, 1'b1);
        check_out("flr_bypass", 64'h900, 1'b1);
        tick();
        check("flr_empty", 80'(bht_update.valid), 80'(0));

        // minimum switch time with an empty queue
        checkpoint_req = 1'b1;
        tick();
        check("min_t1_mode", 80'(checkpoint_mode), 80'(0));
        tick();
        check("min_t2_mode", 80'(checkpoint_mode), 80'(0));
        check("min_t2_busy", 80'(switch_busy), 80'(1));
        tick();
        check("min_t3_mode", 80'(checkpoint_mode), 80'(1));

        // reset with a full queue and mode 1
        bht_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(64'hA00 + 64'(i * 4), 1'b1);
        end
        check("pre_rst_drop", 80'(drop_cnt), 80'(3));
        check("pre_rst_mode", 80'(checkpoint_mode), 80'(1));
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        checkpoint_req = 1'b0;
        check("mid_rst_valid", 80'(bht_update.valid), 80'(0));
        check("mid_rst_pc", 80'(bht_update.pc), 80'(0));
        check("mid_rst_mode", 80'(checkpoint_mode), 80'(0));
        check("mid_rst_busy", 80'(switch_busy), 80'(0));
        check("mid_rst_drop", 80'(drop_cnt), 80'(0));
        bht_ready = 1'b1;
        tick();
        check("post_rst_empty", 80'(bht_update.valid), 80'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
